// File: rtl/rf_wport_arbiter_if.sv
// Signal bundle between the register-file write-port arbiter and its requesters.
// The master side drives the requests and the slave side is the arbiter.
interface rf_wport_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_addr;
  logic [31:0] llu_data;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ack;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        pend1;
  logic        pend2;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;

  modport master (
    output wb_we, wb_addr, wb_data,
    output llu_valid, llu_addr, llu_data,
    output dbg_req, dbg_addr, dbg_data,
    output rd_addr1, rd_addr2,
    input  llu_ready, dbg_ack, pend1, pend2,
    input  RegWrite, Write_register, Write_data
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  llu_valid, llu_addr, llu_data,
    input  dbg_req, dbg_addr, dbg_data,
    input  rd_addr1, rd_addr2,
    output llu_ready, dbg_ack, pend1, pend2,
    output RegWrite, Write_register, Write_data
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between write-back, a buffered long-latency
// unit and a 4-phase debug write path; flags queued destinations for the hazard unit.
module rf_wport_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned STARVE = 8
) (
  input  logic              clk,
  input  logic              reset,
  rf_wport_arbiter_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (STARVE > 1) ? $clog2(STARVE) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE - 1);

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_WAIT = 2'd1;
  localparam logic [1:0] D_ACK  = 2'd2;

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_dstate;
  logic [SW-1:0]    r_starve;

  logic        w_fifo_ne;
  logic        w_dbg_ok;
  logic        w_boost;
  logic        w_grant_fifo;
  logic        w_grant_dbg;
  logic        w_enq;
  logic        w_deq;
  logic        w_gvalid;
  logic [4:0]  w_gaddr;
  logic [31:0] w_gdata;
  logic        w_pend1;
  logic        w_pend2;

  // Debug only competes while its request is still held; a dropped request never writes.
  always_comb begin
    w_fifo_ne    = (r_count != '0);
    w_dbg_ok     = (r_dstate == D_WAIT) && bus.dbg_req;
    w_boost      = w_dbg_ok && (r_starve >= STARVE_MAX);
    w_grant_fifo = !bus.wb_we && !w_boost && w_fifo_ne;
    w_grant_dbg  = !bus.wb_we && w_dbg_ok && (w_boost || !w_fifo_ne);
    w_enq        = bus.llu_valid && bus.llu_ready;
    w_deq        = w_grant_fifo;
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_gaddr  = '0;
    w_gdata  = '0;
    if (bus.wb_we) begin
      w_gvalid = 1'b1;
      w_gaddr  = bus.wb_addr;
      w_gdata  = bus.wb_data;
    end else if (w_grant_dbg) begin
      w_gvalid = 1'b1;
      w_gaddr  = bus.dbg_addr;
      w_gdata  = bus.dbg_data;
    end else if (w_grant_fifo) begin
      w_gvalid = 1'b1;
      w_gaddr  = r_addr[r_rd_ptr];
      w_gdata  = r_data[r_rd_ptr];
    end
  end

  // The head being dequeued this cycle is still reported as pending.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (bus.rd_addr1 != '0) && (r_addr[i] == bus.rd_addr1)) w_pend1 = 1'b1;
      if (r_vld[i] && (bus.rd_addr2 != '0) && (r_addr[i] == bus.rd_addr2)) w_pend2 = 1'b1;
    end
  end

  assign bus.RegWrite       = w_gvalid && (w_gaddr != '0);
  assign bus.Write_register = w_gaddr;
  assign bus.Write_data     = w_gdata;
  assign bus.llu_ready      = (r_count < CW'(DEPTH));
  assign bus.dbg_ack        = (r_dstate == D_ACK);
  assign bus.pend1          = w_pend1;
  assign bus.pend2          = w_pend2;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wr_ptr] <= bus.llu_addr;
      r_data[r_wr_ptr] <= bus.llu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
      else if (!w_enq && w_deq) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dstate <= D_IDLE;
      r_starve <= '0;
    end else begin
      case (r_dstate)
        D_IDLE: begin
          r_starve <= '0;
          if (bus.dbg_req) r_dstate <= D_WAIT;
        end
        D_WAIT: begin
          if (w_grant_dbg) begin
            r_dstate <= D_ACK;
            r_starve <= '0;
          end else if (!bus.dbg_req) begin
            r_dstate <= D_IDLE;
            r_starve <= '0;
          end else if (r_starve < STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        D_ACK: begin
          r_starve <= '0;
          if (!bus.dbg_req) r_dstate <= D_IDLE;
        end
        default: begin
          r_dstate <= D_IDLE;
          r_starve <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: queued long-latency results are scoreboarded
// and popped whenever the port is expected to serve the FIFO.
module tb_rf_wport_arbiter;
  localparam int STARVE   = 8;
  localparam int SRC_NONE = 0;
  localparam int SRC_WB   = 1;
  localparam int SRC_LLU  = 2;
  localparam int SRC_DBG  = 3;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  ent_t llu_q[$];

  rf_wport_arbiter_if bus();

  rf_wport_arbiter #(.DEPTH(2), .STARVE(STARVE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    llu_q.push_back(e);
  endtask

  // Checks the write port against the source that should own it this cycle.
  task automatic port(input int src);
    ent_t e;
    #1;
    case (src)
      SRC_WB: begin
        chk("wb_RegWrite", bus.RegWrite, 1);
        chk("wb_Write_register", bus.Write_register, bus.wb_addr);
        chk("wb_Write_data", bus.Write_data, bus.wb_data);
      end
      SRC_DBG: begin
        chk("dbg_RegWrite", bus.RegWrite, (bus.dbg_addr != 0));
        chk("dbg_Write_register", bus.Write_register, bus.dbg_addr);
        chk("dbg_Write_data", bus.Write_data, bus.dbg_data);
      end
      SRC_LLU: begin
        chk("llu_sb_nonempty", (llu_q.size() != 0), 1);
        if (llu_q.size() != 0) begin
          e = llu_q.pop_front();
          chk("llu_RegWrite", bus.RegWrite, (e.a != 0));
          if (e.a != 0) begin
            chk("llu_Write_register", bus.Write_register, e.a);
            chk("llu_Write_data", bus.Write_data, e.d);
          end
        end
      end
      default: begin
        chk("idle_RegWrite", bus.RegWrite, 0);
        chk("idle_Write_register", bus.Write_register, 0);
        chk("idle_Write_data", bus.Write_data, 0);
      end
    endcase
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.wb_we = 1'b0;  bus.wb_addr = '0;  bus.wb_data = '0;
    bus.llu_valid = 1'b0; bus.llu_addr = '0; bus.llu_data = '0;
    bus.dbg_req = 1'b0; bus.dbg_addr = '0; bus.dbg_data = '0;
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;

    // reset state
    repeat (2) tick();
    port(SRC_NONE);
    chk("rst_llu_ready", bus.llu_ready, 1);
    chk("rst_dbg_ack", bus.dbg_ack, 0);
    chk("rst_pend1", bus.pend1, 0);
    chk("rst_pend2", bus.pend2, 0);
    reset = 1'b1;
    tick();

    // write-back is combinational
    bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
    port(SRC_WB);
    tick();

    // two llu results queued behind write-back traffic
    bus.wb_addr = 5'd20; bus.wb_data = 32'h2020;
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd9; bus.llu_data = 32'hAA;
    bus.rd_addr1 = 5'd9; bus.rd_addr2 = 5'd10;
    push(5'd9, 32'hAA);
    port(SRC_WB);
    chk("q0_llu_ready", bus.llu_ready, 1);
    chk("q0_pend1", bus.pend1, 0);
    tick();
    bus.wb_addr = 5'd21; bus.wb_data = 32'h2121;
    bus.llu_addr = 5'd10; bus.llu_data = 32'hBB;
    push(5'd10, 32'hBB);
    port(SRC_WB);
    chk("q1_llu_ready", bus.llu_ready, 1);
    chk("q1_pend1", bus.pend1, 1);
    chk("q1_pend2", bus.pend2, 0);
    tick();
    bus.wb_addr = 5'd22; bus.wb_data = 32'h2222;
    bus.llu_valid = 1'b0;
    port(SRC_WB);
    chk("full_llu_ready", bus.llu_ready, 0);
    chk("full_pend1", bus.pend1, 1);
    chk("full_pend2", bus.pend2, 1);
    tick();
    bus.wb_we = 1'b0;
    port(SRC_LLU);
    chk("drain0_pend1_head", bus.pend1, 1);
    chk("drain0_llu_ready", bus.llu_ready, 0);
    tick();
    port(SRC_LLU);
    chk("drain1_pend1", bus.pend1, 0);
    chk("drain1_pend2_head", bus.pend2, 1);
    chk("drain1_llu_ready", bus.llu_ready, 1);
    tick();
    port(SRC_NONE);
    chk("drained_llu_ready", bus.llu_ready, 1);
    chk("drained_pend2", bus.pend2, 0);
    tick();

    // debug 4-phase write on an idle port
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd3; bus.dbg_data = 32'hDEAD;
    port(SRC_NONE);
    chk("dbg_idle_ack", bus.dbg_ack, 0);
    tick();
    port(SRC_DBG);
    chk("dbg_wait_ack", bus.dbg_ack, 0);
    tick();
    port(SRC_NONE);
    chk("dbg_ack_1", bus.dbg_ack, 1);
    tick();
    port(SRC_NONE);
    chk("dbg_ack_hold", bus.dbg_ack, 1);
    tick();
    bus.dbg_req = 1'b0;
    port(SRC_NONE);
    chk("dbg_ack_reqlow", bus.dbg_ack, 1);
    tick();
    port(SRC_NONE);
    chk("dbg_ack_done", bus.dbg_ack, 0);
    tick();

    // starvation boost: FIFO kept non-empty while debug waits
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd11; bus.llu_data = 32'h1100;
    push(5'd11, 32'h1100);
    port(SRC_NONE);
    tick();
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd4; bus.dbg_data = 32'hBEEF;
    bus.llu_addr = 5'd12; bus.llu_data = 32'h1200;
    push(5'd12, 32'h1200);
    port(SRC_LLU);
    tick();
    for (int i = 0; i < STARVE - 1; i++) begin
      bus.llu_addr = 5'(13 + i);
      bus.llu_data = 32'h1300 + 32'(i);
      push(5'(13 + i), 32'h1300 + 32'(i));
      port(SRC_LLU);
      chk("starve_wait_ack", bus.dbg_ack, 0);
      tick();
    end
    bus.llu_addr = 5'd24; bus.llu_data = 32'h2400;
    push(5'd24, 32'h2400);
    port(SRC_DBG);
    chk("boost_llu_ready", bus.llu_ready, 1);
    tick();
    bus.llu_valid = 1'b0;
    bus.dbg_req = 1'b0;
    port(SRC_LLU);
    chk("boost_ack", bus.dbg_ack, 1);
    tick();
    port(SRC_LLU);
    chk("boost_ack_clr", bus.dbg_ack, 0);
    tick();
    port(SRC_NONE);
    chk("boost_sb_empty", llu_q.size(), 0);
    tick();

    // register 0 result: consumed without a write, never pending
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd0; bus.llu_data = 32'h77;
    push(5'd0, 32'h77);
    port(SRC_NONE);
    tick();
    bus.llu_valid = 1'b0;
    port(SRC_LLU);
    chk("r0_pend1", bus.pend1, 0);
    chk("r0_pend2", bus.pend2, 0);
    tick();
    port(SRC_NONE);
    chk("r0_llu_ready", bus.llu_ready, 1);
    tick();

    // reset mid-operation with a full FIFO and debug in the ack phase
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd6; bus.dbg_data = 32'h6666;
    port(SRC_NONE);
    tick();
    port(SRC_DBG);
    tick();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd25; bus.wb_data = 32'h2525;
    bus.llu_valid = 1'b1; bus.llu_addr = 5'd13; bus.llu_data = 32'h1313;
    push(5'd13, 32'h1313);
    port(SRC_WB);
    chk("pre_rst_ack", bus.dbg_ack, 1);
    tick();
    bus.wb_addr = 5'd26; bus.wb_data = 32'h2626;
    bus.llu_addr = 5'd14; bus.llu_data = 32'h1414;
    push(5'd14, 32'h1414);
    port(SRC_WB);
    tick();
    bus.wb_we = 1'b0; bus.llu_valid = 1'b0;
    bus.rd_addr1 = 5'd13; bus.rd_addr2 = 5'd14;
    #1;
    chk("pre_rst_llu_ready", bus.llu_ready, 0);
    chk("pre_rst_pend1", bus.pend1, 1);
    chk("pre_rst_pend2", bus.pend2, 1);
    chk("pre_rst_ack2", bus.dbg_ack, 1);
    reset = 1'b0;
    bus.dbg_req = 1'b0;
    llu_q.delete();
    port(SRC_NONE);
    chk("mid_rst_llu_ready", bus.llu_ready, 1);
    chk("mid_rst_ack", bus.dbg_ack, 0);
    chk("mid_rst_pend1", bus.pend1, 0);
    chk("mid_rst_pend2", bus.pend2, 0);
    tick();
    reset = 1'b1;
    port(SRC_NONE);
    tick();
    port(SRC_NONE);
    chk("post_rst_llu_ready", bus.llu_ready, 1);
    chk("post_rst_ack", bus.dbg_ack, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the pipeline write-back stage, a long-latency execution unit (multiply/divide) and the debug write path. It sits directly in front of the register file write inputs (RegWrite, Write_register, Write_data). It buffers long-latency results in a small FIFO and runs a 4-phase handshake FSM for debug writes. It also flags pending writes so the hazard unit can stall readers.

## Interface
- DEPTH, 2: long-latency result FIFO entries (power of 2, ≥2).
- STARVE, 8: cycles a waiting debug request tolerates before it outranks the FIFO.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- wb_we  input  1  write-back stage write request (never stalled).
- wb_addr  input  5  write-back destination register.
- wb_data  input  32  write-back data.
- llu_valid  input  1  long-latency unit result valid.
- llu_ready  output  1  FIFO can accept; transfer when llu_valid & llu_ready.
- llu_addr  input  5  long-latency destination register.
- llu_data  input  32  long-latency result.
- dbg_req  input  1  debug write request (level, 4-phase).
- dbg_addr  input  5  debug destination register, held while dbg_req high.
- dbg_data  input  32  debug write data, held while dbg_req high.
- dbg_ack  output  1  debug write completed.
- rd_addr1  input  5  register-file read address 1 (for hazard check).
- rd_addr2  input  5  register-file read address 2.
- pend1  output  1  rd_addr1 matches a queued FIFO entry.
- pend2  output  1  rd_addr2 matches a queued FIFO entry.
- RegWrite  output  1  register-file write enable.
- Write_register  output  5  register-file write address.
- Write_data  output  32  register-file write data.

## Operation
- The write port is granted combinationally each cycle. Priority: wb_we, then debug (boosted), then the FIFO head, then debug (normal). WB is never blocked.
- Debug is boosted when dbg state is D_WAIT and starve_cnt ≥ STARVE−1.
- The FIFO head is granted when count>0 and neither WB nor boosted debug owns the port. The head is dequeued on that edge.
- Enqueue happens when llu_valid & llu_ready, with llu_ready = (count<DEPTH). Enqueue and dequeue in the same cycle leave count unchanged. Enqueue while full is impossible by construction.
- Register 0: a grant to address 0 still consumes the request (dequeue or ack) but drives RegWrite=0.
- Idle port: RegWrite=0, Write_register=0, Write_data=0.
- Debug FSM:
  - D_IDLE → D_WAIT on dbg_req=1.
  - D_WAIT: on debug grant, write and go to D_ACK. Otherwise starve_cnt increments, saturating at STARVE−1.
  - D_ACK: dbg_ack=1, starve_cnt cleared. Go to D_IDLE when dbg_req=0; otherwise hold.
  - dbg_req falling while in D_WAIT: return to D_IDLE with no write.
- pend1/pend2 are combinational compares of rd_addrN against the addr of every valid FIFO entry. Address 0 never matches. The FIFO head being granted this cycle still counts as pending.

## Timing
- Reset values: llu_ready=1, dbg_ack=0, pend1=pend2=0, RegWrite=0, FIFO empty, FSM in D_IDLE, starve_cnt=0.
- Latency:
  - WB → RegWrite: 0 cycles (combinational).
  - FIFO entry → RegWrite: ≥1 cycle after enqueue.
  - dbg_req rise → earliest write: next cycle (in D_WAIT).
  - Write → dbg_ack: next cycle.
- Maximum debug wait under continuous WB traffic is unbounded, because WB has absolute priority. Under FIFO traffic alone the wait is ≤ STARVE cycles.
- Reset asserted mid-operation immediately flushes the FIFO (queued results are lost), drops dbg_ack and returns the FSM to D_IDLE.
- Simultaneous WB and FIFO writes to the same address: WB writes first, FIFO writes later. This ordering is the hazard unit's responsibility, via pend1/pend2.

## Test plan
- After reset, wb_we=1, wb_addr=5, wb_data=32'h1234 → same cycle RegWrite=1, Write_register=5, Write_data=32'h1234.
- Enqueue llu (addr 9, 32'hAA) and (addr 10, 32'hBB) while wb_we=1 for 3 cycles → llu_ready=0 after 2 enqueues. pend1=1 for rd_addr1=9. Both are written in order once wb_we drops, then llu_ready=1.
- dbg_req with addr 3, data 32'hDEAD and an idle port → write next cycle, dbg_ack=1 on the following cycle. dbg_ack is held until dbg_req falls, then the FSM returns to D_IDLE.
- FIFO kept non-empty continuously plus dbg_req → the debug write occurs after exactly STARVE−1 wait cycles, preempting the FIFO head.
- llu result to addr 0 → dequeued with RegWrite=0, and pend never asserts for rd_addr=0.
- reset pulsed low with 2 entries queued and FSM in D_ACK → FIFO empty, llu_ready=1, dbg_ack=0, no write after reset release.
